// File: rtl/ball_bouncer.sv
// ball_bouncer -- animated pixel source for the hvsync_generator pixel pipeline.
//
// A square ball of BALL_SIZE pixels moves once per frame and bounces off the
// screen limits. The colour output is registered, so the sync outputs in the
// top level must be delayed by one clock to stay aligned with rgb.
//
// Optional feature macro: BALL_BORDER_EN
//   When defined, a red border BORDER pixels thick is drawn around the visible
//   area and the ball bounces off its inner edge instead of the screen edge.
//
// Ports:
//   clk        in   pixel clock (same clock as hvsync_generator)
//   reset      in   asynchronous, active-high
//   hpos       in   [9:0] beam column
//   vpos       in   [9:0] beam line
//   display_on in   visible-area flag
//   pause      in   freezes ball motion while high
//   rgb        out  [2:0] registered colour, bit order {b,g,r}
//   bounce     out  registered one-cycle pulse when either axis reverses
module ball_bouncer #(
  parameter int H_DISPLAY   = 640,
  parameter int V_DISPLAY   = 480,
  parameter int BALL_SIZE   = 8,
  parameter int BALL_HSPEED = 2,
  parameter int BALL_VSPEED = 2,
  parameter int BORDER      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       pause,
  output logic [2:0] rgb,
  output logic       bounce
);

`ifdef BALL_BORDER_EN
  localparam bit BORDER_ON = 1'b1;
`else
  localparam bit BORDER_ON = 1'b0;
`endif

  // Thickness of the band the ball must stay out of (zero without a border).
  localparam int EDGE = BORDER_ON ? BORDER : 0;

  localparam int LO   = EDGE;
  localparam int HI_X = H_DISPLAY - EDGE - BALL_SIZE;
  localparam int HI_Y = V_DISPLAY - EDGE - BALL_SIZE;

  // Start position is the centre of the unbordered range in both builds.
  localparam int X0 = (H_DISPLAY - BALL_SIZE) / 2;
  localparam int Y0 = (V_DISPLAY - BALL_SIZE) / 2;

  logic [9:0] ball_x, ball_y;
  logic       dir_x, dir_y;

  logic [9:0] x_next, y_next;
  logic       dir_x_next, dir_y_next;
  logic       flip_x, flip_y;
  logic       upd;

  // Fires once per frame at the start of vertical blanking, so the ball is
  // never moved while it is being drawn.
  assign upd = (vpos == 10'(V_DISPLAY)) && (hpos == 10'd0);

  // Horizontal step; compares are done in 11 bits so pos+speed cannot wrap.
  always_comb begin
    x_next     = ball_x;
    dir_x_next = dir_x;
    flip_x     = 1'b0;
    if (dir_x) begin
      if ({1'b0, ball_x} + 11'(BALL_HSPEED) >= 11'(HI_X)) begin
        x_next     = 10'(HI_X);
        dir_x_next = 1'b0;
        flip_x     = 1'b1;
      end else begin
        x_next = ball_x + 10'(BALL_HSPEED);
      end
    end else begin
      if ({1'b0, ball_x} <= 11'(LO + BALL_HSPEED)) begin
        x_next     = 10'(LO);
        dir_x_next = 1'b1;
        flip_x     = 1'b1;
      end else begin
        x_next = ball_x - 10'(BALL_HSPEED);
      end
    end
  end

  // Vertical step, same rule as the horizontal axis.
  always_comb begin
    y_next     = ball_y;
    dir_y_next = dir_y;
    flip_y     = 1'b0;
    if (dir_y) begin
      if ({1'b0, ball_y} + 11'(BALL_VSPEED) >= 11'(HI_Y)) begin
        y_next     = 10'(HI_Y);
        dir_y_next = 1'b0;
        flip_y     = 1'b1;
      end else begin
        y_next = ball_y + 10'(BALL_VSPEED);
      end
    end else begin
      if ({1'b0, ball_y} <= 11'(LO + BALL_VSPEED)) begin
        y_next     = 10'(LO);
        dir_y_next = 1'b1;
        flip_y     = 1'b1;
      end else begin
        y_next = ball_y - 10'(BALL_VSPEED);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_x <= 10'(X0);
      ball_y <= 10'(Y0);
      dir_x  <= 1'b1;
      dir_y  <= 1'b1;
      bounce <= 1'b0;
    end else begin
      bounce <= 1'b0;
      if (upd && !pause) begin
        ball_x <= x_next;
        ball_y <= y_next;
        dir_x  <= dir_x_next;
        dir_y  <= dir_y_next;
        // A corner hit flips both axes but still gives a single pulse.
        bounce <= flip_x | flip_y;
      end
    end
  end

  // Pixel decode. Unsigned 10-bit differences turn the two-sided range test
  // into a single compare: positions left of / above the ball wrap to large values.
  logic [9:0] dx, dy;
  logic       hit, border;

  assign dx  = hpos - ball_x;
  assign dy  = vpos - ball_y;
  assign hit = (dx < 10'(BALL_SIZE)) && (dy < 10'(BALL_SIZE));

  assign border = BORDER_ON &&
                  ((hpos < 10'(EDGE)) || (hpos >= 10'(H_DISPLAY - EDGE)) ||
                   (vpos < 10'(EDGE)) || (vpos >= 10'(V_DISPLAY - EDGE)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb <= 3'b000;
    end else if (!display_on) begin
      rgb <= 3'b000;
    end else if (hit) begin
      rgb <= 3'b111;
    end else if (border) begin
      rgb <= 3'b001;
    end else begin
      rgb <= 3'b000;
    end
  end

endmodule

// File: tb/tb_ball_bouncer.sv
// Testbench for ball_bouncer: randomized beam positions and pause patterns
// checked against a velocity-based model of the ball; the ball position is
// observed through the rendered rgb output.
module tb_ball_bouncer;

`ifdef BALL_BORDER_EN
  localparam int EDGE = 8;
  localparam bit BRD  = 1'b1;
`else
  localparam int EDGE = 0;
  localparam bit BRD  = 1'b0;
`endif
  localparam int LO   = EDGE;
  localparam int HI_X = 640 - EDGE - 8;
  localparam int HI_Y = 480 - EDGE - 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] hpos = '0;
  logic [9:0] vpos = '0;
  logic       display_on = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] rgb;
  logic       bounce;

  ball_bouncer dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .pause      (pause),
    .rgb        (rgb),
    .bounce     (bounce)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: position plus signed velocity per axis.
  int mx, my, vx, vy;
  int n_upd;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (ball model x=%0d y=%0d)", tag, got, exp, mx, my);
    end
  endtask

  task automatic model_reset();
    mx = 316; my = 236; vx = 2; vy = 2;
  endtask

  // Move one axis by its velocity; reaching or passing a limit parks the
  // ball on the limit and reverses the velocity.
  task automatic step_axis(inout int p, inout int v, input int lo, input int hi, output bit flip);
    int n;
    n = p + v;
    flip = 1'b0;
    if (n >= hi) begin
      p = hi; v = -v; flip = 1'b1;
    end else if (n <= lo) begin
      p = lo; v = -v; flip = 1'b1;
    end else begin
      p = n;
    end
  endtask

  function automatic int exp_colour(input int h, input int v, input bit d);
    if (!d) return 0;
    if (h >= mx && h < mx + 8 && v >= my && v < my + 8) return 7;
    if (BRD && (h < EDGE || h >= 640 - EDGE || v < EDGE || v >= 480 - EDGE)) return 1;
    return 0;
  endfunction

  // One clock with the given inputs; rgb and bounce are checked #1 after the edge.
  task automatic cycle(input int h, input int v, input bit d, input bit p, input string tag);
    int  er;
    int  eb;
    bit  fx, fy;
    @(negedge clk);
    hpos = 10'(h); vpos = 10'(v); display_on = d; pause = p;
    er = exp_colour(h & 1023, v & 1023, d);
    eb = 0;
    if ((v & 1023) == 480 && (h & 1023) == 0 && !p) begin
      step_axis(mx, vx, LO, HI_X, fx);
      step_axis(my, vy, LO, HI_Y, fy);
      eb = (fx || fy) ? 1 : 0;
      n_upd++;
    end
    @(posedge clk);
    #1;
    chk({tag, ".rgb"}, int'(rgb), er);
    chk({tag, ".bounce"}, int'(bounce), eb);
  endtask

  // Strobe followed by probes around the expected ball corner and a couple
  // of random beam positions.
  task automatic frame(input bit p);
    cycle(0, 480, 1'b0, p, "strobe");
    cycle(mx, my, 1'b1, p, "corner");
    cycle(mx - 1, my, 1'b1, p, "left");
    cycle(mx + 7, my + 7, 1'b1, p, "far_corner");
    cycle(mx + 8, my, 1'b1, p, "right");
    cycle(mx, my - 1, 1'b1, p, "above");
    cycle(mx, my + 8, 1'b1, p, "below");
    for (int k = 0; k < 2; k++)
      cycle(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
            ($urandom_range(0, 3) != 0), p, "random");
  endtask

  initial begin
    model_reset();
    n_upd = 0;

    // Outputs held at zero while reset is asserted, even over the ball.
    hpos = 10'd316; vpos = 10'd236; display_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.rgb", int'(rgb), 0);
    chk("reset.bounce", int'(bounce), 0);
    @(negedge clk);
    reset = 1'b0;

    // Static decode at the centre position.
    cycle(316, 236, 1'b1, 1'b0, "centre");
    cycle(324, 236, 1'b1, 1'b0, "centre_right");
    cycle(316, 236, 1'b0, 1'b0, "centre_blank");
    cycle(3, 100, 1'b1, 1'b0, "left_edge");
    cycle(700, 236, 1'b0, 1'b0, "offscreen");

    // Unpaused run through the first Y bounce (118) and X bounce (158).
    for (int f = 0; f < 160; f++) frame(1'b0);
    cycle(336 - 8 + 16, 256, 1'b1, 1'b0, "probe_after");

    // Paused strobes: nothing moves and no pulse.
    for (int f = 0; f < 5; f++) frame(1'b1);
    for (int f = 0; f < 3; f++) frame(1'b0);

    // Random pause pattern over many bounces.
    for (int f = 0; f < 200; f++) frame($urandom_range(0, 3) == 0);

    // Asynchronous reset in the middle of a line, with rgb lit just before.
    cycle(mx + 2, my + 2, 1'b1, 1'b0, "pre_reset");
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset.rgb", int'(rgb), 0);
    chk("async_reset.bounce", int'(bounce), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    frame(1'b0);
    cycle(318, 238, 1'b1, 1'b0, "after_reset");
    cycle(317, 238, 1'b1, 1'b0, "after_reset_left");
    for (int f = 0; f < 20; f++) frame(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
